tweezer_param_writer: RTL and testbench

Host-side command decoder that drives the parameter/control interface of the tweezer feedback controller.
- Parses a framed byte stream (from the UART/USB bridge) into register writes.
- Holds every controller parameter as a level output and issues one-cycle update strobes for kp/ki.
- Returns an ACK/NAK response byte per frame.

---
 rtl/tweezer_param_writer.sv | 216 +++++++++++++++++++++
 tb/tb_tweezer_param_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweezer_param_writer.sv
// tweezer_param_writer: decodes framed host commands (A5 ADDR DHI DLO CSUM)
// into parameter writes for the tweezer PI feedback controller and answers
// each complete frame with an ACK (0x06) or NAK (0x15) byte.
// Optional build macro READBACK_EN: ADDR bit7 set reads back register
// ADDR[6:0] as ACK, DHI, DLO; without it such addresses are NAKed.
module tweezer_param_writer #(
  parameter int DATA_W         = 16,
  parameter int COEFF_W        = 10,
  parameter int LARGE_COEFF_W  = 10,
  parameter int MULT_ONE       = 128,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [COEFF_W-1:0]       pi_kp,
  output logic [COEFF_W-1:0]       pi_ki,
  output logic                     pi_kp_update,
  output logic                     pi_ki_update,
  output logic [DATA_W-1:0]        pi_setpoint,
  output logic [DATA_W-1:0]        pi_limit_lo,
  output logic [DATA_W-1:0]        pi_limit_hi,
  output logic [DATA_W-1:0]        output_when_pi_disabled,
  output logic [DATA_W-1:0]        sum_div_offset,
  output logic [DATA_W-1:0]        z_offset,
  output logic [LARGE_COEFF_W-1:0] sum_div_multiplier,
  output logic [LARGE_COEFF_W-1:0] z_multiplier,
  output logic                     pi_reset,
  output logic                     pi_enable,
  output logic                     pi_freeze,
  output logic                     add_feedback,
  output logic                     use_sum,
  output logic [7:0]               frame_error_count
);

  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] CSUM_KEY = 8'h5A;
  localparam logic [7:0] LAST_REG = 8'h0A;
  localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM, S_EXEC, S_RESP
  } state_t;

  state_t           r_state;
  logic [7:0]       r_addr;
  logic [7:0]       r_dhi;
  logic [7:0]       r_dlo;
  logic [7:0]       r_csum;
  logic [CNT_W-1:0] r_idle_cnt;

  logic             w_accept;
  logic             w_csum_ok;
  logic             w_is_read;
  logic             w_mapped;
  logic             w_ok;
  logic [7:0]       w_idx;
  logic [15:0]      w_data;

`ifdef READBACK_EN
  logic [15:0]      w_rd_val;
  logic [15:0]      r_rd_word;
  logic [1:0]       r_rd_left;
`endif

  // Bytes are only taken while a frame is being collected, never while a
  // command executes or its response waits for the host.
  assign rx_ready  = (r_state != S_EXEC) && (r_state != S_RESP);
  assign w_accept  = rx_valid && rx_ready;
  assign w_data    = {r_dhi, r_dlo};
  assign w_csum_ok = (r_csum == (r_addr ^ r_dhi ^ r_dlo ^ CSUM_KEY));
`ifdef READBACK_EN
  assign w_is_read = r_addr[7];
  assign w_idx     = {1'b0, r_addr[6:0]};
`else
  assign w_is_read = 1'b0;
  assign w_idx     = r_addr;
`endif
  assign w_mapped  = (w_idx <= LAST_REG);
  assign w_ok      = w_csum_ok && w_mapped;

`ifdef READBACK_EN
  // Zero-extended view of the addressed register for read commands.
  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      8'h00:   w_rd_val = 16'(pi_kp);
      8'h01:   w_rd_val = 16'(pi_ki);
      8'h02:   w_rd_val = 16'(pi_setpoint);
      8'h03:   w_rd_val = 16'(pi_limit_lo);
      8'h04:   w_rd_val = 16'(pi_limit_hi);
      8'h05:   w_rd_val = 16'(output_when_pi_disabled);
      8'h06:   w_rd_val = 16'(sum_div_offset);
      8'h07:   w_rd_val = 16'(sum_div_multiplier);
      8'h08:   w_rd_val = 16'(z_offset);
      8'h09:   w_rd_val = 16'(z_multiplier);
      8'h0A:   w_rd_val = {11'd0, use_sum, add_feedback, pi_freeze, pi_enable, pi_reset};
      default: w_rd_val = '0;
    endcase
  end
`endif

  // Frame FSM with registered parameter outputs, strobes and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                 <= S_IDLE;
      r_addr                  <= '0;
      r_dhi                   <= '0;
      r_dlo                   <= '0;
      r_csum                  <= '0;
      r_idle_cnt              <= '0;
      tx_data                 <= '0;
      tx_valid                <= 1'b0;
      pi_kp                   <= '0;
      pi_ki                   <= '0;
      pi_kp_update            <= 1'b0;
      pi_ki_update            <= 1'b0;
      pi_setpoint             <= '0;
      pi_limit_lo             <= {1'b1, {(DATA_W-1){1'b0}}};
      pi_limit_hi             <= {1'b0, {(DATA_W-1){1'b1}}};
      output_when_pi_disabled <= '0;
      sum_div_offset          <= '0;
      z_offset                <= '0;
      sum_div_multiplier      <= LARGE_COEFF_W'(MULT_ONE);
      z_multiplier            <= LARGE_COEFF_W'(MULT_ONE);
      {use_sum, add_feedback, pi_freeze, pi_enable, pi_reset} <= 5'b00001;
      frame_error_count       <= '0;
`ifdef READBACK_EN
      r_rd_word               <= '0;
      r_rd_left               <= '0;
`endif
    end else begin
      pi_kp_update <= 1'b0;
      pi_ki_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (rx_data == SOF)) begin
            r_state    <= S_ADDR;
            r_idle_cnt <= '0;
          end
        end
        S_ADDR, S_DHI, S_DLO, S_CSUM: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            case (r_state)
              S_ADDR:  begin r_addr <= rx_data; r_state <= S_DHI;  end
              S_DHI:   begin r_dhi  <= rx_data; r_state <= S_DLO;  end
              S_DLO:   begin r_dlo  <= rx_data; r_state <= S_CSUM; end
              default: begin r_csum <= rx_data; r_state <= S_EXEC; end
            endcase
          end else if (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            // Stalled host: abandon the partial frame without a reply.
            r_state <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          r_state  <= S_RESP;
          tx_valid <= 1'b1;
          if (!w_ok) begin
            tx_data <= NAK;
            if (frame_error_count != 8'hFF) frame_error_count <= frame_error_count + 8'd1;
          end else begin
            tx_data <= ACK;
`ifdef READBACK_EN
            if (w_is_read) begin
              r_rd_word <= w_rd_val;
              r_rd_left <= 2'd2;
            end else
`endif
            begin
              case (w_idx)
                8'h00: begin pi_kp <= w_data[COEFF_W-1:0]; pi_kp_update <= 1'b1; end
                8'h01: begin pi_ki <= w_data[COEFF_W-1:0]; pi_ki_update <= 1'b1; end
                8'h02: pi_setpoint             <= w_data[DATA_W-1:0];
                8'h03: pi_limit_lo             <= w_data[DATA_W-1:0];
                8'h04: pi_limit_hi             <= w_data[DATA_W-1:0];
                8'h05: output_when_pi_disabled <= w_data[DATA_W-1:0];
                8'h06: sum_div_offset          <= w_data[DATA_W-1:0];
                8'h07: sum_div_multiplier      <= w_data[LARGE_COEFF_W-1:0];
                8'h08: z_offset                <= w_data[DATA_W-1:0];
                8'h09: z_multiplier            <= w_data[LARGE_COEFF_W-1:0];
                8'h0A: {use_sum, add_feedback, pi_freeze, pi_enable, pi_reset} <= w_data[4:0];
                default: ;
              endcase
            end
          end
        end
        S_RESP: begin
          if (tx_ready) begin
`ifdef READBACK_EN
            if (r_rd_left != 2'd0) begin
              tx_data   <= (r_rd_left == 2'd2) ? r_rd_word[15:8] : r_rd_word[7:0];
              r_rd_left <= r_rd_left - 2'd1;
            end else
`endif
            begin
              tx_valid <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tweezer_param_writer.sv
// Self-checking bench for tweezer_param_writer: directed frames from the
// test plan, then randomized frames checked against a register-map model.
module tb_tweezer_param_writer;

  localparam int DATA_W         = 16;
  localparam int COEFF_W        = 10;
  localparam int LARGE_COEFF_W  = 10;
  localparam int MULT_ONE       = 128;
  localparam int TIMEOUT_CYCLES = 100;
`ifdef READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [7:0]               rx_data = '0;
  logic                     rx_valid = 1'b0;
  logic                     rx_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready = 1'b0;
  logic [COEFF_W-1:0]       pi_kp, pi_ki;
  logic                     pi_kp_update, pi_ki_update;
  logic [DATA_W-1:0]        pi_setpoint, pi_limit_lo, pi_limit_hi;
  logic [DATA_W-1:0]        output_when_pi_disabled, sum_div_offset, z_offset;
  logic [LARGE_COEFF_W-1:0] sum_div_multiplier, z_multiplier;
  logic                     pi_reset, pi_enable, pi_freeze, add_feedback, use_sum;
  logic [7:0]               frame_error_count;

  tweezer_param_writer #(
    .DATA_W(DATA_W), .COEFF_W(COEFF_W), .LARGE_COEFF_W(LARGE_COEFF_W),
    .MULT_ONE(MULT_ONE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pi_kp(pi_kp), .pi_ki(pi_ki),
    .pi_kp_update(pi_kp_update), .pi_ki_update(pi_ki_update),
    .pi_setpoint(pi_setpoint), .pi_limit_lo(pi_limit_lo), .pi_limit_hi(pi_limit_hi),
    .output_when_pi_disabled(output_when_pi_disabled),
    .sum_div_offset(sum_div_offset), .z_offset(z_offset),
    .sum_div_multiplier(sum_div_multiplier), .z_multiplier(z_multiplier),
    .pi_reset(pi_reset), .pi_enable(pi_enable), .pi_freeze(pi_freeze),
    .add_feedback(add_feedback), .use_sum(use_sum),
    .frame_error_count(frame_error_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         exp_reg[11];
  int         exp_err;
  logic [7:0] exp_tx[$];
  bit         exp_kp_upd, exp_ki_upd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int reg_width(input int i);
    case (i)
      0, 1:    return COEFF_W;
      7, 9:    return LARGE_COEFF_W;
      10:      return 5;
      default: return DATA_W;
    endcase
  endfunction

  function automatic void model_reset();
    exp_reg = '{0, 0, 0, 'h8000, 'h7FFF, 0, 0, MULT_ONE, 0, MULT_ONE, 1};
    exp_err = 0;
  endfunction

  // Register-map model: decides the reply bytes and the register effect of one frame.
  function automatic void model_frame(input logic [7:0] addr, dhi, dlo, csum);
    logic [7:0] idx;
    bit rd, ok;
    exp_tx.delete();
    exp_kp_upd = 1'b0;
    exp_ki_upd = 1'b0;
    rd  = RB && addr[7];
    idx = rd ? {1'b0, addr[6:0]} : addr;
    ok  = (csum == (addr ^ dhi ^ dlo ^ 8'h5A)) && (idx <= 8'd10);
    if (!ok) begin
      exp_tx.push_back(8'h15);
      if (exp_err < 255) exp_err++;
    end else if (rd) begin
      exp_tx.push_back(8'h06);
      exp_tx.push_back(8'((exp_reg[idx] >> 8) & 'hFF));
      exp_tx.push_back(8'(exp_reg[idx] & 'hFF));
    end else begin
      exp_reg[idx] = {16'd0, dhi, dlo} & ((1 << reg_width(int'(idx))) - 1);
      exp_tx.push_back(8'h06);
      exp_kp_upd = (idx == 8'd0);
      exp_ki_upd = (idx == 8'd1);
    end
  endfunction

  function automatic int dut_reg(input int i);
    case (i)
      0:  return int'(pi_kp);
      1:  return int'(pi_ki);
      2:  return int'(pi_setpoint);
      3:  return int'(pi_limit_lo);
      4:  return int'(pi_limit_hi);
      5:  return int'(output_when_pi_disabled);
      6:  return int'(sum_div_offset);
      7:  return int'(sum_div_multiplier);
      8:  return int'(z_offset);
      9:  return int'(z_multiplier);
      default: return int'({use_sum, add_feedback, pi_freeze, pi_enable, pi_reset});
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 11; i++) chk($sformatf("%s_reg%0d", tag, i), dut_reg(i), exp_reg[i]);
    chk({tag, "_errcnt"}, frame_error_count, exp_err);
  endtask

  // Presents one byte after 'gap' idle cycles and waits (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!rx_ready) chk("rx_accept_wait", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] addr, dhi, dlo, csum, input int hold, input int gap);
    send_byte(8'hA5, gap);
    send_byte(addr, gap);
    send_byte(dhi, gap);
    send_byte(dlo, gap);
    send_byte(csum, gap);
    // Execute cycle: nothing visible yet.
    chk("exec_txv", tx_valid, 0);
    chk("exec_rxr", rx_ready, 0);
    chk("exec_kpu", pi_kp_update, 0);
    chk("exec_kiu", pi_ki_update, 0);
    check_all("exec");
    model_frame(addr, dhi, dlo, csum);
    @(posedge clk); #1;
    chk("resp_txv", tx_valid, 1);
    chk("resp_tx0", tx_data, exp_tx[0]);
    chk("resp_kpu", pi_kp_update, exp_kp_upd);
    chk("resp_kiu", pi_ki_update, exp_ki_upd);
    check_all("resp");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_txv", tx_valid, 1);
      chk("hold_rxr", rx_ready, 0);
      chk("hold_tx", tx_data, exp_tx[0]);
      chk("hold_kpu", pi_kp_update, 0);
      chk("hold_kiu", pi_ki_update, 0);
    end
    for (int k = 0; k < exp_tx.size(); k++) begin
      chk($sformatf("tx_byte%0d", k), tx_data, exp_tx[k]);
      chk("tx_valid_pend", tx_valid, 1);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      chk("post_kpu", pi_kp_update, 0);
      chk("post_kiu", pi_ki_update, 0);
    end
    chk("end_txv", tx_valid, 0);
    chk("end_rxr", rx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, dh, dl, cs, junk;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all("reset");
    chk("reset_txv", tx_valid, 0);
    chk("reset_txd", tx_data, 0);
    chk("reset_rxr", rx_ready, 1);
    chk("reset_kpu", pi_kp_update, 0);

    // kp write, bad checksum, control write with a stalled host.
    do_frame(8'h00, 8'h01, 8'h2C, 8'h77, 0, 0);
    do_frame(8'h00, 8'h01, 8'h2C, 8'h00, 0, 0);
    do_frame(8'h0A, 8'h00, 8'h02, 8'h52, 10, 0);
    chk("ctl_enable", pi_enable, 1);
    chk("ctl_reset", pi_reset, 0);

    // Partial frame abandoned by the idle timeout.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    repeat (TIMEOUT_CYCLES + 1) @(posedge clk);
    #1;
    chk("tmo_txv", tx_valid, 0);
    chk("tmo_rxr", rx_ready, 1);
    do_frame(8'h01, 8'h00, 8'h05, 8'h5E, 0, 0);
    chk("tmo_ki", pi_ki, 5);
    chk("tmo_kp", pi_kp, 'h12C);

    // Unmapped address, then a read command (NAK unless readback is built in).
    do_frame(8'h0F, 8'h00, 8'h00, 8'h55, 0, 0);
    do_frame(8'h80, 8'h00, 8'h00, 8'hDA, 1, 0);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all("midrst");
    chk("midrst_txv", tx_valid, 0);
    chk("midrst_rxr", rx_ready, 1);
    do_frame(8'h03, 8'h80, 8'h00, 8'hD9, 0, 0);
    chk("lim_lo", pi_limit_lo, 'h8000);

    // Randomized frames with junk between them.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, 0);
      end
      case ($urandom_range(0, 3))
        0, 1: a = 8'($urandom_range(0, 10));
        2:    a = 8'($urandom_range(0, 127));
        default: a = 8'h80 | 8'($urandom_range(0, 15));
      endcase
      dh = 8'($urandom_range(0, 255));
      dl = 8'($urandom_range(0, 255));
      cs = a ^ dh ^ dl ^ 8'h5A;
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      do_frame(a, dh, dl, cs, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Error counter saturation.
    for (int it = 0; it < 260; it++) begin
      dh = 8'($urandom_range(0, 255));
      do_frame(8'h02, dh, 8'h00, dh ^ 8'h5A ^ 8'h02 ^ 8'h01, 0, 0);
    end
    chk("err_sat", frame_error_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
